// File: rtl/fractal_sync_pkg.sv
// Shared helpers for the fractal sync dispatcher.
// Index widths are clamped so a single-entry range still gets one bit.
package fractal_sync_pkg;

  localparam int unsigned MIN_IDX_W = 1;

  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : MIN_IDX_W;
  endfunction

endpackage

// File: rtl/fractal_sync_mw_fifo.sv
// Multi-write FIFO: up to IN_PORTS pushes and one pop per cycle.
// Optional fall-through via FRACTAL_SYNC_DISPATCHER_FALL_THROUGH_EN.
module fractal_sync_mw_fifo
  import fractal_sync_pkg::*;
#(
  parameter int unsigned IN_PORTS = 1,
  parameter int unsigned DEPTH    = 4,
  parameter type element_t        = logic
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [IN_PORTS-1:0] req_i,
  input  element_t            element_i [IN_PORTS],
  input  logic                pop_i,
  output logic                empty_o,
  output element_t            element_o,
  output logic                drop_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = idx_w(DEPTH);

  element_t            mem [DEPTH];
  logic [CW-1:0]       count;
  logic [CW-1:0]       stored;
  logic [PW-1:0]       rptr;
  logic [PW-1:0]       wptr;
  logic [PW-1:0]       slot [IN_PORTS];
  logic [IN_PORTS-1:0] wr_en;
  logic                ft;
  logic                pop_mem;

  function automatic logic [PW-1:0] wrap(
    logic [PW-1:0] p,
    int unsigned   k
  );
    int unsigned s;
    s = 32'(p) + k;
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

`ifdef FRACTAL_SYNC_DISPATCHER_FALL_THROUGH_EN
  element_t ft_data;

  always_comb begin
    ft_data = element_i[0];
    for (int i = int'(IN_PORTS) - 1; i >= 0; i--)
      if (req_i[i]) ft_data = element_i[i];
  end

  assign ft = (count == '0) && (|req_i);
  assign element_o = ft ? ft_data :
                     (count == '0) ? '0 : mem[rptr];
`else
  assign ft = 1'b0;
  assign element_o = (count == '0) ? '0 : mem[rptr];
`endif

  assign empty_o = (count == '0) && !ft;
  assign pop_mem = pop_i && (count != '0);

  // Space is judged on the start-of-cycle count; a popped
  // fall-through element is consumed and never stored.
  always_comb begin
    int unsigned free;
    int unsigned acc;
    int unsigned n;
    logic        skip;
    free   = DEPTH - 32'(count);
    acc    = 0;
    n      = 0;
    skip   = ft && pop_i;
    wr_en  = '0;
    drop_o = 1'b0;
    for (int i = 0; i < int'(IN_PORTS); i++) begin
      slot[i] = '0;
      if (req_i[i]) begin
        if (acc < free) begin
          acc++;
          if (skip) begin
            skip = 1'b0;
          end else begin
            wr_en[i] = 1'b1;
            slot[i]  = wrap(wptr, n);
            n++;
          end
        end else begin
          drop_o = 1'b1;
        end
      end
    end
    stored = CW'(n);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
      rptr  <= '0;
      wptr  <= '0;
    end else begin
      count <= count + stored - CW'(pop_mem);
      wptr  <= wrap(wptr, 32'(stored));
      if (pop_mem) rptr <= wrap(rptr, 1);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(IN_PORTS); i++)
      if (wr_en[i]) mem[slot[i]] <= element_i[i];
  end

endmodule

// File: rtl/fractal_sync_dispatcher.sv
// Routes producer lanes into per-destination multi-write FIFOs.
// Optional fall-through via FRACTAL_SYNC_DISPATCHER_FALL_THROUGH_EN.
module fractal_sync_dispatcher
  import fractal_sync_pkg::*;
#(
  parameter int unsigned IN_PORTS  = 1,
  parameter int unsigned OUT_PORTS = 1,
  parameter int unsigned DEPTH     = 4,
  parameter type element_t         = logic,
  localparam int unsigned DST_W    = idx_w(OUT_PORTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [IN_PORTS-1:0]  valid_i,
  input  logic [DST_W-1:0]     dst_i [IN_PORTS],
  input  element_t             element_i [IN_PORTS],
  output logic [OUT_PORTS-1:0] empty_o,
  input  logic [OUT_PORTS-1:0] pop_i,
  output element_t             element_o [OUT_PORTS],
  output logic                 overflow_o
);

  if (IN_PORTS == 0 || OUT_PORTS == 0 || DEPTH == 0) begin : g_bad_cfg
    $fatal(1, "fractal_sync_dispatcher: zero-sized parameter");
  end

  logic [OUT_PORTS-1:0] drop;
  logic                 bad_dst;

  always_comb begin
    bad_dst = 1'b0;
    for (int i = 0; i < int'(IN_PORTS); i++)
      if (valid_i[i] && (32'(dst_i[i]) >= OUT_PORTS))
        bad_dst = 1'b1;
  end

  for (genvar o = 0; o < int'(OUT_PORTS); o++) begin : g_queue
    logic [IN_PORTS-1:0] req;

    always_comb begin
      for (int i = 0; i < int'(IN_PORTS); i++)
        req[i] = valid_i[i] && (32'(dst_i[i]) == 32'(o));
    end

    fractal_sync_mw_fifo #(
      .IN_PORTS  (IN_PORTS),
      .DEPTH     (DEPTH),
      .element_t (element_t)
    ) u_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (req),
      .element_i (element_i),
      .pop_i     (pop_i[o]),
      .empty_o   (empty_o[o]),
      .element_o (element_o[o]),
      .drop_o    (drop[o])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_o <= 1'b0;
    end else if (bad_dst || (|drop)) begin
      overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fractal_sync_dispatcher.sv
// Bench: two dispatcher configs against a queue-based reference model.
// Honours FRACTAL_SYNC_DISPATCHER_FALL_THROUGH_EN when defined.
module tb_fractal_sync_dispatcher;

`ifdef FRACTAL_SYNC_DISPATCHER_FALL_THROUGH_EN
  localparam bit FT = 1'b1;
`else
  localparam bit FT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0] valid_a, pop_a, empty_a;
  logic [0:0] dst_a [2];
  logic [7:0] el_a [2];
  logic [7:0] out_a [2];
  logic       ovf_a;

  logic [1:0] valid_b;
  logic [2:0] pop_b, empty_b;
  logic [1:0] dst_b [2];
  logic [7:0] el_b [2];
  logic [7:0] out_b [3];
  logic       ovf_b;

  fractal_sync_dispatcher #(
    .IN_PORTS(2), .OUT_PORTS(2), .DEPTH(4),
    .element_t(logic [7:0])
  ) u_a (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_a),
    .dst_i(dst_a), .element_i(el_a), .empty_o(empty_a),
    .pop_i(pop_a), .element_o(out_a), .overflow_o(ovf_a)
  );

  fractal_sync_dispatcher #(
    .IN_PORTS(2), .OUT_PORTS(3), .DEPTH(3),
    .element_t(logic [7:0])
  ) u_b (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_b),
    .dst_i(dst_b), .element_i(el_b), .empty_o(empty_b),
    .pop_i(pop_b), .element_o(out_b), .overflow_o(ovf_b)
  );

  // Reference: queues 0-2 model u_a (0-1 used), 3-5 model u_b.
  logic [7:0] mq [6][$];
  bit         mo [2];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(int inst, int outs, int depth,
                            logic [1:0] v, int d0, int d1,
                            logic [7:0] e0, logic [7:0] e1,
                            logic [2:0] p);
    int         base;
    int         pre [3];
    int         acc [3];
    int         d [2];
    logic [7:0] e [2];
    base = inst * 3;
    d[0] = d0; d[1] = d1;
    e[0] = e0; e[1] = e1;
    for (int q = 0; q < 3; q++) begin
      pre[q] = mq[base+q].size();
      acc[q] = 0;
    end
    for (int i = 0; i < 2; i++) begin
      if (v[i]) begin
        if (d[i] >= outs) begin
          mo[inst] = 1'b1;
        end else if (acc[d[i]] < depth - pre[d[i]]) begin
          mq[base+d[i]].push_back(e[i]);
          acc[d[i]]++;
        end else begin
          mo[inst] = 1'b1;
        end
      end
    end
    for (int q = 0; q < outs; q++)
      if (p[q] && (pre[q] > 0 || (FT && acc[q] > 0)))
        void'(mq[base+q].pop_front());
  endtask

  function automatic logic [7:0] head(int k);
    return (mq[k].size() != 0) ? mq[k][0] : 8'h00;
  endfunction

  task automatic check_all();
    for (int q = 0; q < 2; q++) begin
      chk($sformatf("a.empty%0d", q), 32'(empty_a[q]),
          32'(mq[q].size() == 0));
      chk($sformatf("a.elem%0d", q), 32'(out_a[q]), 32'(head(q)));
    end
    chk("a.overflow", 32'(ovf_a), 32'(mo[0]));
    for (int q = 0; q < 3; q++) begin
      chk($sformatf("b.empty%0d", q), 32'(empty_b[q]),
          32'(mq[3+q].size() == 0));
      chk($sformatf("b.elem%0d", q), 32'(out_b[q]), 32'(head(3+q)));
    end
    chk("b.overflow", 32'(ovf_b), 32'(mo[1]));
  endtask

  task automatic idle();
    valid_a = '0; pop_a = '0; valid_b = '0; pop_b = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0, 2, 4, valid_a, int'(dst_a[0]), int'(dst_a[1]),
               el_a[0], el_a[1], {1'b0, pop_a});
    model_step(1, 3, 3, valid_b, int'(dst_b[0]), int'(dst_b[1]),
               el_b[0], el_b[1], pop_b);
    #1 idle();
    #1 check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) mq[k].delete();
    mo[0] = 1'b0; mo[1] = 1'b0;
    chk("rst.empty_a", 32'(empty_a), 32'h3);
    chk("rst.empty_b", 32'(empty_b), 32'h7);
    chk("rst.ovf_a", 32'(ovf_a), 32'h0);
    chk("rst.ovf_b", 32'(ovf_b), 32'h0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    for (int i = 0; i < 2; i++) begin
      dst_a[i] = '0; el_a[i] = '0; dst_b[i] = '0; el_b[i] = '0;
    end
    rst_n = 1'b1;
    #2 do_reset();

    // lane0 -> queue1 visible next cycle
    valid_a = 2'b01; dst_a[0] = 1'b1; el_a[0] = 8'hA1;
    cycle();
    chk("q1.empty", 32'(empty_a), 32'h1);
    chk("q1.elem", 32'(out_a[1]), 32'hA1);
    pop_a = 2'b10;
    cycle();

    // two lanes same queue, ordered by lane index
    valid_a = 2'b11; dst_a[0] = 1'b0; dst_a[1] = 1'b0;
    el_a[0] = 8'hAA; el_a[1] = 8'hBB;
    cycle();
    chk("order.first", 32'(out_a[0]), 32'hAA);
    pop_a = 2'b01;
    cycle();
    chk("order.second", 32'(out_a[0]), 32'hBB);
    pop_a = 2'b01;
    cycle();
    chk("order.empty", 32'(empty_a[0]), 32'h1);

    // three queued, two writes plus a pop: only lane0 fits
    valid_a = 2'b11; el_a[0] = 8'h10; el_a[1] = 8'h11;
    cycle();
    valid_a = 2'b01; el_a[0] = 8'h12;
    cycle();
    valid_a = 2'b11; el_a[0] = 8'h31; el_a[1] = 8'h32; pop_a = 2'b01;
    cycle();
    chk("full.ovf", 32'(ovf_a), 32'h1);
    chk("full.head", 32'(out_a[0]), 32'h11);
    for (int k = 0; k < 3; k++) begin
      chk("full.notempty", 32'(empty_a[0]), 32'h0);
      pop_a = 2'b01;
      cycle();
    end
    chk("full.drained", 32'(empty_a[0]), 32'h1);

    // pop on empty, then an out-of-range destination
    pop_b = 3'b001;
    cycle();
    chk("popempty.empty", 32'(empty_b), 32'h7);
    chk("popempty.ovf", 32'(ovf_b), 32'h0);
    valid_b = 2'b01; dst_b[0] = 2'd3; el_b[0] = 8'h77;
    cycle();
    chk("baddst.ovf", 32'(ovf_b), 32'h1);
    chk("baddst.empty", 32'(empty_b), 32'h7);

    // reset with entries queued
    valid_a = 2'b11; dst_a[0] = 1'b1; dst_a[1] = 1'b1;
    el_a[0] = 8'h21; el_a[1] = 8'h22;
    cycle();
    do_reset();

    // depth-3 queue wraps while streaming
    for (int k = 0; k < 7; k++) begin
      valid_b = 2'b01; dst_b[0] = 2'd2; el_b[0] = 8'(8'h40 + k);
      pop_b = (k >= 2) ? 3'b100 : 3'b000;
      cycle();
      chk("wrap.head", 32'(out_b[2]), (k < 2) ? 32'h40 : 32'(8'h40 + k - 1));
    end
    for (int k = 0; k < 3; k++) begin
      pop_b = 3'b100;
      cycle();
    end
    chk("wrap.empty", 32'(empty_b[2]), 32'h1);

`ifdef FRACTAL_SYNC_DISPATCHER_FALL_THROUGH_EN
    do_reset();
    valid_a = 2'b01; dst_a[0] = 1'b0; el_a[0] = 8'h5A; pop_a = 2'b01;
    #1;
    chk("ft.empty", 32'(empty_a[0]), 32'h0);
    chk("ft.elem", 32'(out_a[0]), 32'h5A);
    cycle();
    chk("ft.after", 32'(empty_a[0]), 32'h1);
`endif

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      valid_a = 2'($urandom);
      pop_a   = 2'($urandom);
      valid_b = 2'($urandom);
      pop_b   = 3'($urandom);
      for (int i = 0; i < 2; i++) begin
        dst_a[i] = 1'($urandom);
        el_a[i]  = 8'($urandom);
        dst_b[i] = 2'($urandom_range(0, 3));
        el_b[i]  = 8'($urandom);
      end
      cycle();
      if ($urandom_range(0, 79) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
